// File: rtl/fifo_uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared types and line levels for the FIFO-fed UART transmitter.
//   - tx_state_t : transmitter FSM state encoding
//   - START_LVL / STOP_LVL / IDLE_LVL : serial line levels
// ----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx_if
//   FIFO read-port bundle between the byte FIFO and its UART drain stage.
//   Signals:
//     fifo_empty  FIFO empty flag                  (FIFO -> drain)
//     fifo_data   FIFO data_out, valid 1 cycle
//                 after fifo_rd_en                 (FIFO -> drain)
//     fifo_rd_en  single-cycle read strobe         (drain -> FIFO)
//   Modports:
//     master : drain side (issues reads)
//     slave  : FIFO side (answers reads)
// ----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_W = 8
);

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );

endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_bit_timer
//   Counts clk cycles within one UART bit period.
//   Ports:
//     clk          system clock
//     rst          synchronous active-high reset
//     clear        force the count back to 0 (line not in a bit period)
//     enable       advance the count this cycle
//     bit_end      high on the last cycle of a bit period
//     bit_pre_end  high on the cycle before the last one, so callers can
//                  register an output that lands on the last cycle
// ----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end     = enable && (cnt_q == LAST);
    assign bit_pre_end = enable && (cnt_q == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for the 8-bit byte FIFO. Pops a byte whenever the FIFO is
//   non-empty and the line is idle, then sends it as an 8N1 UART frame
//   (start, 8 data bits LSB first, stop).
//   Build option: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the last data bit and the stop bit (8E1 frame).
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     fifo       FIFO read port (fifo_uart_tx_if.master)
//     tx         serial line, idle high, registered
//     busy       registered (state != IDLE)
//     byte_done  1-cycle pulse on the last cycle of each stop bit
// ----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    tx_state_t         state_q, state_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              byte_done_q, byte_done_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic timer_en;
    logic bit_end;
    logic bit_pre_end;

    // Timer runs only while a bit is on the line; IDLE/FETCH hold it at 0 so
    // START always begins a full bit period.
    assign timer_en = (state_q != IDLE) && (state_q != FETCH);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (!timer_en),
        .enable      (timer_en),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    // Read strobe is combinational so the FIFO data lands in FETCH.
    always_comb begin
        fifo.fifo_rd_en = (state_q == IDLE) && !fifo.fifo_empty && !rst;
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        byte_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d = IDLE_LVL;
                if (!fifo.fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo.fifo_data;
`ifdef UART_TX_PARITY_EN
                par_d   = ^fifo.fifo_data;
`endif
                idx_d   = 3'd0;
                tx_d    = START_LVL;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = STOP_LVL;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (bit_end) begin
                    tx_d    = STOP_LVL;
                    state_d = STOP;
                end
`else
                // Unreachable without parity; recover to a clean idle line.
                tx_d    = IDLE_LVL;
                state_d = IDLE;
`endif
            end
            STOP: begin
                // Registered pulse: decided one cycle early to hit the last cycle.
                byte_done_d = bit_pre_end;
                if (bit_end) begin
                    tx_d    = IDLE_LVL;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = IDLE_LVL;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= IDLE_LVL;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule
